// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller. Holds the displayed value,
// walks one shared hex decoder across the digits and drives one-hot digit
// enables plus segments. New values are staged in a one-deep pending buffer
// and only become visible at frame boundaries (or while the display is off).
module seg_scan_ctrl #(
    parameter int DATA_W         = 8,
    parameter int NUM_DIGITS     = DATA_W / 4,
    parameter int REFRESH_DIV    = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load_valid,
    input  logic [DATA_W-1:0]     load_data,
    output logic                  load_ready,
    input  logic                  blank_lz,
    output logic [3:0]            dec_bin,
    input  logic [0:6]            dec_sev,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic [0:6]            seg_out,
    output logic                  frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV - 1) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 2);
    localparam logic [0:6]       SEG_BLANK = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                  state, state_nx;
    logic [IDX_W-1:0]        idx, idx_nx;
    logic [CNT_W-1:0]        cnt, cnt_nx;
    logic [DATA_W-1:0]       active, active_nx;
    logic [DATA_W-1:0]       pend, pend_nx;
    logic                    pend_valid, pend_valid_nx;
    logic [NUM_DIGITS-1:0]   digit_en_nx;
    logic [0:6]              seg_nx;
    logic                    frame_done_nx;
    logic                    digit_blank;

    // Digit i>0 is a leading zero when it and every more-significant nibble are 0.
    function automatic logic lz_blank(input logic [DATA_W-1:0] val,
                                      input logic [IDX_W-1:0]  i,
                                      input logic              lz);
        logic zero_above;
        zero_above = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((k >= int'(i)) && (val[4*k +: 4] != 4'h0))
                zero_above = 1'b0;
        end
        return lz && (i != '0) && zero_above;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_DIGITS-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (i == IDX_W'(k))
                v[k] = 1'b1;
        end
        return v;
    endfunction

    assign load_ready  = ~pend_valid;
    assign digit_blank = lz_blank(active, idx, blank_lz);

    // Select the nibble of the current digit for the shared decoder.
    always_comb begin
        dec_bin = active[3:0];
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k))
                dec_bin = active[4*k +: 4];
        end
    end

    // Next-state, pending-buffer handoff and registered-output next values.
    always_comb begin
        state_nx      = state;
        idx_nx        = idx;
        cnt_nx        = cnt;
        active_nx     = active;
        pend_nx       = pend;
        pend_valid_nx = pend_valid;
        digit_en_nx   = digit_en;
        seg_nx        = seg_out;
        frame_done_nx = 1'b0;

        // Accept only into an empty buffer, so accept and handoff never overlap.
        if (load_valid && !pend_valid) begin
            pend_nx       = load_data;
            pend_valid_nx = 1'b1;
        end

        // While dark there is no frame to tear, so take the pending value at once.
        if ((state == S_OFF) && pend_valid) begin
            active_nx     = pend;
            pend_valid_nx = 1'b0;
        end

        if (!en) begin
            state_nx    = S_OFF;
            idx_nx      = '0;
            cnt_nx      = '0;
            digit_en_nx = '0;
            seg_nx      = SEG_BLANK;
        end else begin
            unique case (state)
                S_OFF: begin
                    idx_nx      = '0;
                    digit_en_nx = '0;
                    seg_nx      = SEG_BLANK;
                    state_nx    = S_FETCH;
                end
                S_FETCH: begin
                    // Blanked digits keep their slot so the frame period is fixed.
                    seg_nx      = digit_blank ? SEG_BLANK
                                : (SEG_ACTIVE_LOW ? ~dec_sev : dec_sev);
                    digit_en_nx = digit_blank ? '0 : onehot(idx);
                    cnt_nx      = '0;
                    state_nx    = S_HOLD;
                end
                S_HOLD: begin
                    if (cnt == CNT_LAST) begin
                        // Dark for the FETCH cycle to avoid ghosting on the next digit.
                        digit_en_nx = '0;
                        state_nx    = S_FETCH;
                        if (idx == IDX_LAST) begin
                            idx_nx        = '0;
                            frame_done_nx = 1'b1;
                            if (pend_valid) begin
                                active_nx     = pend;
                                pend_valid_nx = 1'b0;
                            end
                        end else begin
                            idx_nx = idx + 1'b1;
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: state_nx = S_OFF;
            endcase
        end
    end

    // State and output registers; reset drops everything including pending data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_OFF;
            idx        <= '0;
            cnt        <= '0;
            active     <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            digit_en   <= '0;
            seg_out    <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            cnt        <= cnt_nx;
            active     <= active_nx;
            pend       <= pend_nx;
            pend_valid <= pend_valid_nx;
            digit_en   <= digit_en_nx;
            seg_out    <= seg_nx;
            frame_done <= frame_done_nx;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: stimulus pushes per-cycle expected outputs,
// a monitor on the falling edge pops and compares both an active-high and an
// active-low instance driven by identical inputs.
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, en, load_valid, blank_lz;
    logic [7:0] load_data;

    logic       load_ready, frame_done;
    logic [3:0] dec_bin;
    logic [0:6] dec_sev, seg_out;
    logic [1:0] digit_en;

    logic       load_ready_al, frame_done_al;
    logic [3:0] dec_bin_al;
    logic [0:6] dec_sev_al, seg_out_al;
    logic [1:0] digit_en_al;

    int checks = 0;
    int errors = 0;

    localparam logic [0:6] S0 = 7'b1111110;
    localparam logic [0:6] S1 = 7'b0110000;
    localparam logic [0:6] S2 = 7'b1101101;
    localparam logic [0:6] S3 = 7'b1111001;
    localparam logic [0:6] S5 = 7'b1011011;
    localparam logic [0:6] S8 = 7'b1111111;
    localparam logic [0:6] SC = 7'b1001110;
    localparam logic [0:6] SB = 7'b0000000;

    typedef struct {
        string      name;
        logic [1:0] den;
        logic [0:6] seg;
        logic [3:0] bin;
        logic       fd;
        logic       lr;
    } exp_t;

    exp_t q[$];
    exp_t me;

    always #5 clk = ~clk;

    function automatic logic [0:6] hex7(input logic [3:0] b);
        case (b)
            4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;  default: return 7'b1000111;
        endcase
    endfunction

    assign dec_sev    = hex7(dec_bin);
    assign dec_sev_al = hex7(dec_bin_al);

    seg_scan_ctrl #(.DATA_W(8), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load_valid(load_valid),
        .load_data(load_data), .load_ready(load_ready), .blank_lz(blank_lz),
        .dec_bin(dec_bin), .dec_sev(dec_sev), .digit_en(digit_en),
        .seg_out(seg_out), .frame_done(frame_done)
    );

    seg_scan_ctrl #(.DATA_W(8), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst_n(rst_n), .en(en), .load_valid(load_valid),
        .load_data(load_data), .load_ready(load_ready_al), .blank_lz(blank_lz),
        .dec_bin(dec_bin_al), .dec_sev(dec_sev_al), .digit_en(digit_en_al),
        .seg_out(seg_out_al), .frame_done(frame_done_al)
    );

    // Monitor: one expected record per sampled cycle, checked on both instances.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            checks++;
            if (digit_en !== me.den || seg_out !== me.seg || dec_bin !== me.bin ||
                frame_done !== me.fd || load_ready !== me.lr) begin
                errors++;
                $display("FAIL %s t=%0t got den=%b seg=%b bin=%h fd=%b lr=%b want den=%b seg=%b bin=%h fd=%b lr=%b",
                         me.name, $time, digit_en, seg_out, dec_bin, frame_done, load_ready,
                         me.den, me.seg, me.bin, me.fd, me.lr);
            end
            checks++;
            if (digit_en_al !== me.den || seg_out_al !== ~me.seg || dec_bin_al !== me.bin ||
                frame_done_al !== me.fd || load_ready_al !== me.lr) begin
                errors++;
                $display("FAIL %s_al t=%0t got den=%b seg=%b bin=%h fd=%b lr=%b want den=%b seg=%b bin=%h fd=%b lr=%b",
                         me.name, $time, digit_en_al, seg_out_al, dec_bin_al, frame_done_al, load_ready_al,
                         me.den, ~me.seg, me.bin, me.fd, me.lr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string nm, input logic [1:0] den, input logic [0:6] seg,
                        input logic [3:0] bin, input logic fd, input logic lr);
        exp_t e;
        e.name = nm; e.den = den; e.seg = seg; e.bin = bin; e.fd = fd; e.lr = lr;
        q.push_back(e);
    endtask

    // One 8-cycle frame at REFRESH_DIV=4: FETCH d0, 3x HOLD d0, FETCH d1, 3x HOLD d1.
    task automatic frame_exp(input string nm, input logic [3:0] n0, input logic [3:0] n1,
                             input logic [0:6] s0, input logic [0:6] s1,
                             input logic [1:0] e0, input logic [1:0] e1,
                             input logic [0:6] sprev, input logic fd,
                             input logic [7:0] lrv, input int nent);
        for (int j = 0; j < nent; j++) begin
            case (j)
                0:       push(nm, 2'b00, sprev, n0, fd,   lrv[j]);
                1, 2, 3: push(nm, e0,    s0,    n0, 1'b0, lrv[j]);
                4:       push(nm, 2'b00, s0,    n1, 1'b0, lrv[j]);
                default: push(nm, e1,    s1,    n1, 1'b0, lrv[j]);
            endcase
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; load_valid = 1'b0; load_data = 8'h00; blank_lz = 1'b0;

        tick(); push("reset", 2'b00, SB, 4'h0, 1'b0, 1'b1);
        tick(); push("reset", 2'b00, SB, 4'h0, 1'b0, 1'b1);

        // T1: load 3C while off, then scan
        tick(); rst_n = 1'b1; load_valid = 1'b1; load_data = 8'h3C;
        push("t1_off_load", 2'b00, SB, 4'h0, 1'b0, 1'b1);
        tick(); load_valid = 1'b0; en = 1'b1;
        push("t1_off_pend", 2'b00, SB, 4'h0, 1'b0, 1'b0);
        tick(); frame_exp("t1_f1", 4'hC, 4'h3, SC, S3, 2'b01, 2'b10, SB, 1'b0, 8'hFF, 8); repeat (7) tick();
        tick(); frame_exp("t1_f2", 4'hC, 4'h3, SC, S3, 2'b01, 2'b10, S3, 1'b1, 8'hFF, 8); repeat (7) tick();

        // T3: mid-frame load of 12, second load while pending is ignored
        tick(); frame_exp("t3_pend", 4'hC, 4'h3, SC, S3, 2'b01, 2'b10, S3, 1'b1, 8'h01, 8);
        load_valid = 1'b1; load_data = 8'h12;
        tick(); load_data = 8'h77;
        tick();
        tick(); load_valid = 1'b0;
        repeat (4) tick();
        tick(); frame_exp("t3_new", 4'h2, 4'h1, S2, S1, 2'b01, 2'b10, S3, 1'b1, 8'h01, 8);
        load_valid = 1'b1; load_data = 8'h05; blank_lz = 1'b1;
        tick(); load_valid = 1'b0; repeat (6) tick();

        // T2: leading-zero blanking of 05, then 00
        tick(); frame_exp("t2_lz5", 4'h5, 4'h0, S5, SB, 2'b01, 2'b00, S1, 1'b1, 8'h01, 8);
        load_valid = 1'b1; load_data = 8'h00;
        tick(); load_valid = 1'b0; repeat (6) tick();
        tick(); frame_exp("t2_zero", 4'h0, 4'h0, S0, SB, 2'b01, 2'b00, SB, 1'b1, 8'h01, 8);
        load_valid = 1'b1; load_data = 8'h88;
        tick(); load_valid = 1'b0; repeat (6) tick();

        // T6: 88 lights every segment (all zeros on the active-low instance)
        tick(); frame_exp("t6_88", 4'h8, 4'h8, S8, S8, 2'b01, 2'b10, SB, 1'b1, 8'hFF, 8); repeat (7) tick();

        // T4: en drops during digit1 HOLD, then restarts at idx 0
        tick(); frame_exp("t4_en", 4'h8, 4'h8, S8, S8, 2'b01, 2'b10, S8, 1'b1, 8'hFF, 6); repeat (5) tick();
        en = 1'b0;
        push("t4_off", 2'b00, SB, 4'h8, 1'b0, 1'b1);
        push("t4_off", 2'b00, SB, 4'h8, 1'b0, 1'b1);
        tick(); tick(); en = 1'b1;
        tick(); frame_exp("t4_restart", 4'h8, 4'h8, S8, S8, 2'b01, 2'b10, SB, 1'b0, 8'hFF, 8); repeat (7) tick();

        // T5: async reset mid-HOLD with a pending value that must be lost
        tick(); frame_exp("t5_hold", 4'h8, 4'h8, S8, S8, 2'b01, 2'b10, S8, 1'b1, 8'h01, 2);
        load_valid = 1'b1; load_data = 8'hA5;
        tick(); load_valid = 1'b0;
        tick(); push("t5_rst", 2'b00, SB, 4'h0, 1'b0, 1'b1); #2 rst_n = 1'b0;
        tick(); push("t5_rst", 2'b00, SB, 4'h0, 1'b0, 1'b1); rst_n = 1'b1;
        tick(); frame_exp("t5_restart", 4'h0, 4'h0, S0, SB, 2'b01, 2'b00, SB, 1'b0, 8'hFF, 8); repeat (7) tick();

        repeat (2) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
